// File: rtl/bp_update_sequencer.sv
// Update-port sequencer for the tournament branch predictor: arbitrates execute/decode
// updates into a small FIFO, issues one update per cycle, and sweeps a clear index
// over every predictor entry after reset and on flush.
//
// state | meaning
// INIT  | post-reset sweep of all 2^N entries; clear_req ignored
// RUN   | drain FIFO head onto the predictor update port
// CLEAR | flush-triggered sweep of all 2^N entries
module bp_update_sequencer #(
  parameter int N     = 13,
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [XLEN-1:0] a_pc,
  input  logic [XLEN-1:0] a_target,
  input  logic            a_taken,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [XLEN-1:0] b_pc,
  input  logic [XLEN-1:0] b_target,
  input  logic            clear_req,
  output logic            busy,
  output logic            we,
  output logic [XLEN-1:0] PCUpdate,
  output logic [XLEN-1:0] targetUpdate,
  output logic            takenUpdate,
  output logic            clr_en,
  output logic [N-1:0]    clr_index
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {INIT, RUN, CLEAR} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } entry_t;

  state_t         state_q, state_d;
  logic           clr_en_q, clr_en_d;
  logic [N-1:0]   clr_index_q, clr_index_d;
  logic           busy_q, busy_d;
  logic           we_q, we_d;
  entry_t         out_q, out_d;
  logic           ready_q, ready_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  entry_t         mem_q [DEPTH];

  logic   enq_a, enq_b, enq, flush, pop_ok, pop_mem, bypass, wr_en;
  entry_t in_entry;

  // Arbitration: A wins ties; ready comes from a registered count so a draining full FIFO never accepts.
  always_comb begin
    enq_a    = a_valid & ready_q;
    enq_b    = b_valid & ready_q & ~a_valid;
    enq      = enq_a | enq_b;
    in_entry = enq_a ? entry_t'{a_pc, a_target, a_taken} : entry_t'{b_pc, b_target, 1'b1};
    flush    = clear_req & (state_q != INIT);
  end

  // Sequencer next-state: sweeps restart at 0 on flush; INIT arms its first index the cycle after reset.
  always_comb begin
    state_d     = state_q;
    clr_en_d    = clr_en_q;
    clr_index_d = clr_index_q;
    busy_d      = busy_q;
    if (flush) begin
      state_d     = CLEAR;
      clr_en_d    = 1'b1;
      clr_index_d = '0;
      busy_d      = 1'b1;
    end else begin
      case (state_q)
        INIT, CLEAR: begin
          if (!clr_en_q) begin
            clr_en_d    = 1'b1;
            clr_index_d = '0;
          end else if (clr_index_q == '1) begin
            state_d     = RUN;
            clr_en_d    = 1'b0;
            busy_d      = 1'b0;
            clr_index_d = '0;
          end else begin
            clr_index_d = clr_index_q + N'(1);
          end
        end
        RUN: begin
          clr_en_d = 1'b0;
          busy_d   = 1'b0;
        end
        default: state_d = INIT;
      endcase
    end
  end

  // FIFO and output stage: an enqueue into an empty FIFO goes straight to the output register.
  always_comb begin
    pop_ok  = (state_d == RUN);
    pop_mem = 1'b0;
    bypass  = 1'b0;
    wr_en   = 1'b0;
    we_d    = 1'b0;
    out_d   = out_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_ok && count_q != '0) begin
        pop_mem = 1'b1;
        we_d    = 1'b1;
        out_d   = mem_q[head_q];
        head_d  = head_q + PW'(1);
      end else if (pop_ok && enq) begin
        bypass = 1'b1;
        we_d   = 1'b1;
        out_d  = in_entry;
      end
      if (enq && !bypass) begin
        wr_en  = 1'b1;
        tail_d = tail_q + PW'(1);
      end
      if (wr_en && !pop_mem) count_d = count_q + CW'(1);
      else if (!wr_en && pop_mem) count_d = count_q - CW'(1);
    end
    ready_d = (count_d < CW'(DEPTH));
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= INIT;
      clr_en_q    <= 1'b0;
      clr_index_q <= '0;
      busy_q      <= 1'b1;
      we_q        <= 1'b0;
      out_q       <= '0;
      ready_q     <= 1'b0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_en_q    <= clr_en_d;
      clr_index_q <= clr_index_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      out_q       <= out_d;
      ready_q     <= ready_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem_q[tail_q] <= in_entry;
  end

  assign a_ready      = ready_q;
  assign b_ready      = ready_q & ~a_valid;
  assign busy         = busy_q;
  assign we           = we_q;
  assign PCUpdate     = out_q.pc;
  assign targetUpdate = out_q.target;
  assign takenUpdate  = out_q.taken;
  assign clr_en       = clr_en_q;
  assign clr_index    = clr_index_q;

endmodule
